// File: rtl/display_pkg.sv
// Shared types, default 640x480@60 timing and the rectangle span test for the
// UNO display path.
package display_pkg;

  localparam int DEF_H_ACTIVE = 640;
  localparam int DEF_H_FP     = 16;
  localparam int DEF_H_SYNC   = 96;
  localparam int DEF_H_BP     = 48;
  localparam int DEF_V_ACTIVE = 480;
  localparam int DEF_V_FP     = 10;
  localparam int DEF_V_SYNC   = 2;
  localparam int DEF_V_BP     = 33;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } rgb_t;

  typedef struct packed {
    logic       en;
    logic [9:0] x;
    logic [9:0] y;
    logic [9:0] w;
    logic [9:0] h;
    rgb_t       rgb;
  } layer_cfg_t;

  // Per-pixel timing context carried alongside the background latency.
  typedef struct packed {
    logic [9:0] h;
    logic [9:0] v;
    logic       hs_n;
    logic       vs_n;
    logic       active;
  } pix_ctx_t;

  localparam pix_ctx_t CTX_IDLE = '{h: 10'd0, v: 10'd0, hs_n: 1'b1, vs_n: 1'b1, active: 1'b0};

  // End point is formed at 11 bits so start+len never wraps back below 1024.
  function automatic logic in_span(input logic [9:0] p, input logic [9:0] start,
                                   input logic [9:0] len);
    logic [10:0] stop;
    stop = {1'b0, start} + {1'b0, len};
    return (p >= start) && ({1'b0, p} < stop);
  endfunction

endpackage

// File: rtl/vga_timing_gen.sv
// Horizontal/vertical counters with sync, active-area and commit-point decode,
// all combinational from the counter registers.
module vga_timing_gen
  import display_pkg::*;
#(
  parameter int H_ACTIVE = DEF_H_ACTIVE,
  parameter int H_FP     = DEF_H_FP,
  parameter int H_SYNC   = DEF_H_SYNC,
  parameter int H_BP     = DEF_H_BP,
  parameter int V_ACTIVE = DEF_V_ACTIVE,
  parameter int V_FP     = DEF_V_FP,
  parameter int V_SYNC   = DEF_V_SYNC,
  parameter int V_BP     = DEF_V_BP
) (
  input  logic       clk_i,
  input  logic       rst_i,
  output logic [9:0] h_o,
  output logic [9:0] v_o,
  output logic       hs_n_o,
  output logic       vs_n_o,
  output logic       active_o,
  output logic       frame_start_o
);

  localparam logic [9:0] H_VIS  = 10'(H_ACTIVE);
  localparam logic [9:0] HS_BEG = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] HS_END = 10'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [9:0] H_LAST = 10'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
  localparam logic [9:0] V_VIS  = 10'(V_ACTIVE);
  localparam logic [9:0] VS_BEG = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] VS_END = 10'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [9:0] V_LAST = 10'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);

  logic [9:0] h_q, h_d;
  logic [9:0] v_q, v_d;

  always_comb begin
    h_d = h_q + 10'd1;
    v_d = v_q;
    if (h_q == H_LAST) begin
      h_d = '0;
      v_d = (v_q == V_LAST) ? '0 : v_q + 10'd1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      h_q <= '0;
      v_q <= '0;
    end else begin
      h_q <= h_d;
      v_q <= v_d;
    end
  end

  assign h_o           = h_q;
  assign v_o           = v_q;
  assign hs_n_o        = !((h_q >= HS_BEG) && (h_q < HS_END));
  assign vs_n_o        = !((v_q >= VS_BEG) && (v_q < VS_END));
  assign active_o      = (h_q < H_VIS) && (v_q < V_VIS);
  assign frame_start_o = (h_q == '0) && (v_q == V_VIS);

endmodule

// File: rtl/vga_layer_compositor.sv
// VGA engine: timing, background-latency alignment, double-buffered rectangle
// layers and a registered priority mux onto the DAC pins.
module vga_layer_compositor
  import display_pkg::*;
#(
  parameter int H_ACTIVE   = DEF_H_ACTIVE,
  parameter int H_FP       = DEF_H_FP,
  parameter int H_SYNC     = DEF_H_SYNC,
  parameter int H_BP       = DEF_H_BP,
  parameter int V_ACTIVE   = DEF_V_ACTIVE,
  parameter int V_FP       = DEF_V_FP,
  parameter int V_SYNC     = DEF_V_SYNC,
  parameter int V_BP       = DEF_V_BP,
  parameter int NUM_LAYERS = 4,
  parameter int BG_LAT     = 1,
  parameter int LW         = (NUM_LAYERS > 1) ? $clog2(NUM_LAYERS) : 1
) (
  input  logic          i_clk_25M,
  input  logic          i_rst,
  input  logic [23:0]   i_bg_rgb,
  input  logic          i_cfg_we,
  input  logic [LW-1:0] i_cfg_layer,
  input  logic          i_cfg_en,
  input  logic [9:0]    i_cfg_x,
  input  logic [9:0]    i_cfg_y,
  input  logic [9:0]    i_cfg_w,
  input  logic [9:0]    i_cfg_h,
  input  logic [23:0]   i_cfg_rgb,
  output logic [9:0]    o_x_cnt,
  output logic [9:0]    o_y_cnt,
  output logic          o_frame_start,
  output logic [7:0]    VGA_R,
  output logic [7:0]    VGA_G,
  output logic [7:0]    VGA_B,
  output logic          VGA_HS,
  output logic          VGA_VS,
  output logic          VGA_BLANK_N,
  output logic          VGA_SYNC_N,
  output logic          VGA_CLK
);

  logic [9:0] h0, v0;
  logic       hs_n0, vs_n0, active0, frame_start;
  pix_ctx_t   ctx0, ctx_dly;

  vga_timing_gen #(
    .H_ACTIVE(H_ACTIVE), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
    .V_ACTIVE(V_ACTIVE), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP)
  ) u_timing (
    .clk_i        (i_clk_25M),
    .rst_i        (i_rst),
    .h_o          (h0),
    .v_o          (v0),
    .hs_n_o       (hs_n0),
    .vs_n_o       (vs_n0),
    .active_o     (active0),
    .frame_start_o(frame_start)
  );

  assign ctx0 = {h0, v0, hs_n0, vs_n0, active0};

  generate
    if (BG_LAT == 0) begin : g_no_dly
      assign ctx_dly = ctx0;
    end else begin : g_dly
      pix_ctx_t dly_q [BG_LAT];
      always_ff @(posedge i_clk_25M) begin
        if (i_rst) begin
          for (int i = 0; i < BG_LAT; i++) dly_q[i] <= CTX_IDLE;
        end else begin
          dly_q[0] <= ctx0;
          for (int i = 1; i < BG_LAT; i++) dly_q[i] <= dly_q[i-1];
        end
      end
      assign ctx_dly = dly_q[BG_LAT-1];
    end
  endgenerate

  layer_cfg_t shadow_q [NUM_LAYERS];
  layer_cfg_t active_q [NUM_LAYERS];
  layer_cfg_t wr_cfg;
  logic       wr_ok;

  assign wr_cfg = '{en: i_cfg_en, x: i_cfg_x, y: i_cfg_y, w: i_cfg_w, h: i_cfg_h,
                    rgb: rgb_t'(i_cfg_rgb)};
  assign wr_ok  = i_cfg_we && (int'(i_cfg_layer) < NUM_LAYERS);

  // Commit copies the pre-edge shadow, so a write on the commit clock waits a frame.
  always_ff @(posedge i_clk_25M) begin
    if (i_rst) begin
      for (int i = 0; i < NUM_LAYERS; i++) begin
        shadow_q[i] <= '0;
        active_q[i] <= '0;
      end
    end else begin
      if (wr_ok) shadow_q[i_cfg_layer] <= wr_cfg;
      if (frame_start) begin
        for (int i = 0; i < NUM_LAYERS; i++) active_q[i] <= shadow_q[i];
      end
    end
  end

  rgb_t pix_d, rgb_q;
  logic hs_n_q, vs_n_q, blank_n_q;

  always_comb begin
    pix_d = rgb_t'(i_bg_rgb);
    for (int i = 0; i < NUM_LAYERS; i++) begin
      if (active_q[i].en &&
          in_span(ctx_dly.h, active_q[i].x, active_q[i].w) &&
          in_span(ctx_dly.v, active_q[i].y, active_q[i].h))
        pix_d = active_q[i].rgb;
    end
    if (!ctx_dly.active) pix_d = '0;
  end

  always_ff @(posedge i_clk_25M) begin
    if (i_rst) begin
      rgb_q     <= '0;
      hs_n_q    <= 1'b1;
      vs_n_q    <= 1'b1;
      blank_n_q <= 1'b0;
    end else begin
      rgb_q     <= pix_d;
      hs_n_q    <= ctx_dly.hs_n;
      vs_n_q    <= ctx_dly.vs_n;
      blank_n_q <= ctx_dly.active;
    end
  end

  assign o_x_cnt       = h0;
  assign o_y_cnt       = v0;
  assign o_frame_start = frame_start;
  assign VGA_R         = rgb_q.r;
  assign VGA_G         = rgb_q.g;
  assign VGA_B         = rgb_q.b;
  assign VGA_HS        = hs_n_q;
  assign VGA_VS        = vs_n_q;
  assign VGA_BLANK_N   = blank_n_q;
  assign VGA_SYNC_N    = 1'b0;
  assign VGA_CLK       = ~i_clk_25M;

endmodule
